// File: rtl/zsdram_frame_fetch.sv
// Streams a frame buffer out of SDRAM in 4-word bursts into a first-word-fall-through pixel FIFO.
// Optional underrun counter is built only when FETCH_UNDERRUN_CNT_EN is defined.
module zsdram_frame_fetch #(
    parameter logic [23:0] FB_BASE     = 24'h000000,
    parameter int          FRAME_WORDS = 130560,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        oRd_Req,
    output logic [23:0] oRd_Addr,
    input  logic        iRd_Done,
    input  logic [15:0] iRd_Data1,
    input  logic [15:0] iRd_Data2,
    input  logic [15:0] iRd_Data3,
    input  logic [15:0] iRd_Data4,
    input  logic        iFrame_Start,
    input  logic        iPix_Pop,
    output logic        oPix_Valid,
    output logic [15:0] oPix_Data,
    output logic        oFrame_Wrap,
    output logic [15:0] oUnderrun_Cnt
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [24:0]     FB_END   = {1'b0, FB_BASE} + 25'(FRAME_WORDS);
    localparam logic [PTR_W:0]  ROOM_MAX = (PTR_W + 1)'(FIFO_DEPTH - 4);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, PUSH = 2'd2, FLUSH = 2'd3} state_t;
    state_t state, state_nxt;

    logic [23:0]      addr;
    logic [23:0]      rd_addr;
    logic             pending;
    logic             frame_wrap;
    logic [1:0]       push_idx;
    logic [15:0]      stage [4];
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [15:0]      hold_data;
    logic             fifo_empty;
    logic             fifo_room;
    logic             push_en;
    logic             pop_en;
    logic             last_push;
    logic             start_req;
    logic [24:0]      addr_adv;

    assign fifo_empty = (count == '0);
    assign fifo_room  = (count <= ROOM_MAX);
    assign push_en    = (state == PUSH) && !iFrame_Start;
    assign pop_en     = iPix_Pop && !fifo_empty;
    assign last_push  = push_en && (push_idx == 2'd3);
    assign start_req  = (state == IDLE) && (state_nxt == REQ);
    assign addr_adv   = {1'b0, addr} + 25'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (iFrame_Start)
                    state_nxt = FLUSH;
                else if (en && !pending && fifo_room)
                    state_nxt = REQ;
            end
            REQ: begin
                // A restart seen during the request lets it finish, then drops its data.
                if (iRd_Done)
                    state_nxt = (pending || iFrame_Start) ? FLUSH : PUSH;
            end
            PUSH: begin
                if (iFrame_Start)
                    state_nxt = FLUSH;
                else if (push_idx == 2'd3)
                    state_nxt = IDLE;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oRd_Req = (state == REQ);
    end

    assign oRd_Addr    = rd_addr;
    assign oPix_Valid  = !fifo_empty;
    assign oPix_Data   = fifo_empty ? hold_data : mem[rd_ptr];
    assign oFrame_Wrap = frame_wrap;

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr] <= stage[push_idx];
        if ((state == REQ) && iRd_Done) begin
            stage[0] <= iRd_Data1;
            stage[1] <= iRd_Data2;
            stage[2] <= iRd_Data3;
            stage[3] <= iRd_Data4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= FB_BASE;
            rd_addr    <= '0;
            pending    <= 1'b0;
            frame_wrap <= 1'b0;
            push_idx   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_data  <= '0;
        end else begin
            frame_wrap <= 1'b0;
            // Empty FIFO keeps showing the last head word, so underruns never disturb the output.
            hold_data  <= oPix_Data;
            if (start_req)
                rd_addr <= addr;
            if ((state == REQ) && iFrame_Start)
                pending <= 1'b1;
            if (state != PUSH)
                push_idx <= '0;
            else if (push_en)
                push_idx <= push_idx + 2'd1;
            if (last_push) begin
                if (addr_adv >= FB_END) begin
                    addr       <= FB_BASE;
                    frame_wrap <= 1'b1;
                end else begin
                    addr <= addr_adv[23:0];
                end
            end
            if (state == FLUSH) begin
                addr    <= FB_BASE;
                pending <= 1'b0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
            end else begin
                if (push_en)
                    wr_ptr <= wr_ptr + (PTR_W)'(1);
                if (pop_en)
                    rd_ptr <= rd_ptr + (PTR_W)'(1);
                if (push_en && !pop_en)
                    count <= count + (PTR_W + 1)'(1);
                else if (!push_en && pop_en)
                    count <= count - (PTR_W + 1)'(1);
            end
        end
    end

`ifdef FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || iFrame_Start)
            underrun_cnt <= '0;
        else if (iPix_Pop && fifo_empty)
            underrun_cnt <= sat_inc16(underrun_cnt);
    end

    assign oUnderrun_Cnt = underrun_cnt;
`else
    assign oUnderrun_Cnt = '0;
`endif

endmodule

// File: tb/tb_zsdram_frame_fetch.sv
// Randomized bench for zsdram_frame_fetch: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_zsdram_frame_fetch;
    localparam logic [23:0] FB_BASE     = 24'h000000;
    localparam int          FRAME_WORDS = 16;
    localparam int          FIFO_DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        iRd_Done = 1'b0;
    logic [15:0] iRd_Data1 = '0, iRd_Data2 = '0, iRd_Data3 = '0, iRd_Data4 = '0;
    logic        iFrame_Start = 1'b0;
    logic        iPix_Pop = 1'b0;
    logic        oRd_Req;
    logic [23:0] oRd_Addr;
    logic        oPix_Valid;
    logic [15:0] oPix_Data;
    logic        oFrame_Wrap;
    logic [15:0] oUnderrun_Cnt;

    zsdram_frame_fetch #(
        .FB_BASE(FB_BASE), .FRAME_WORDS(FRAME_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .oRd_Req(oRd_Req), .oRd_Addr(oRd_Addr), .iRd_Done(iRd_Done),
        .iRd_Data1(iRd_Data1), .iRd_Data2(iRd_Data2), .iRd_Data3(iRd_Data3), .iRd_Data4(iRd_Data4),
        .iFrame_Start(iFrame_Start), .iPix_Pop(iPix_Pop),
        .oPix_Valid(oPix_Valid), .oPix_Data(oPix_Data),
        .oFrame_Wrap(oFrame_Wrap), .oUnderrun_Cnt(oUnderrun_Cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel queue, words waiting to be pushed, and transaction flags.
    logic [15:0] mq[$];
    logic [15:0] mpush[$];
    bit          m_req, m_pending, m_flush, m_wrap;
    logic [23:0] m_addr, m_rd_addr;
    logic [15:0] m_last, m_ucnt;
    logic [15:0] pop_log[$];

    always @(posedge clk) begin : model
        logic [15:0] cur;
        bit          valid;
        int          sz;
        valid = (mq.size() != 0);
        cur   = valid ? mq[0] : m_last;
        sz    = mq.size();
        if (!rst && iPix_Pop && oPix_Valid)
            pop_log.push_back(oPix_Data);
        if (rst) begin
            mq.delete();
            mpush.delete();
            m_req = 0; m_pending = 0; m_flush = 0; m_wrap = 0;
            m_addr = FB_BASE; m_rd_addr = '0; m_last = '0; m_ucnt = '0;
        end else begin
`ifdef FETCH_UNDERRUN_CNT_EN
            if (iFrame_Start)
                m_ucnt = '0;
            else if (iPix_Pop && !valid && m_ucnt != 16'hFFFF)
                m_ucnt = m_ucnt + 16'd1;
`endif
            m_wrap = 0;
            m_last = cur;
            if (m_flush) begin
                mq.delete();
                m_addr = FB_BASE;
                m_pending = 0;
                m_flush = 0;
            end else begin
                if (iPix_Pop && valid)
                    void'(mq.pop_front());
                if (m_req) begin
                    if (iFrame_Start) m_pending = 1;
                    if (iRd_Done) begin
                        m_req = 0;
                        if (m_pending) m_flush = 1;
                        else mpush = '{iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4};
                    end
                end else if (mpush.size() != 0) begin
                    if (iFrame_Start) begin
                        mpush.delete();
                        m_flush = 1;
                    end else begin
                        mq.push_back(mpush.pop_front());
                        if (mpush.size() == 0) begin
                            if (int'(m_addr) + 4 >= int'(FB_BASE) + FRAME_WORDS) begin
                                m_addr = FB_BASE;
                                m_wrap = 1;
                            end else begin
                                m_addr = m_addr + 24'd4;
                            end
                        end
                    end
                end else begin
                    if (iFrame_Start) m_flush = 1;
                    else if (en && !m_pending && (FIFO_DEPTH - sz >= 4)) begin
                        m_req = 1;
                        m_rd_addr = m_addr;
                    end
                end
            end
        end
    end

    int          nreq = 0, nwrap = 0;
    logic [23:0] req_log[$];
    bit          prev_req = 0;

    always @(posedge clk) begin : compare
        #1;
        check("rd_req", oRd_Req, m_req);
        check("rd_addr", oRd_Addr, m_rd_addr);
        check("pix_valid", oPix_Valid, mq.size() != 0);
        check("pix_data", oPix_Data, (mq.size() != 0) ? mq[0] : m_last);
        check("frame_wrap", oFrame_Wrap, m_wrap);
        check("underrun_cnt", oUnderrun_Cnt, m_ucnt);
        if (oRd_Req && !prev_req) begin
            nreq++;
            req_log.push_back(oRd_Addr);
        end
        prev_req = oRd_Req;
        if (oFrame_Wrap) nwrap++;
    end

    // Arbiter: answers each request after arb_delay cycles with a one-cycle done pulse.
    int          arb_delay = 5;
    int          wait_cnt = 0;
    bit          arb_rand = 0;
    bit          arb_on = 1;
    logic [15:0] next_val = 16'd1;

    always @(negedge clk) begin : arbiter
        if (arb_on) begin
            if (rst) begin
                iRd_Done = 1'b0;
                wait_cnt = 0;
            end else if (iRd_Done) begin
                iRd_Done = 1'b0;
                wait_cnt = 0;
            end else if (oRd_Req) begin
                wait_cnt++;
                if (wait_cnt >= arb_delay) begin
                    iRd_Done = 1'b1;
                    if (arb_rand) begin
                        iRd_Data1 = 16'($urandom); iRd_Data2 = 16'($urandom);
                        iRd_Data3 = 16'($urandom); iRd_Data4 = 16'($urandom);
                        arb_delay = $urandom_range(1, 6);
                    end else begin
                        iRd_Data1 = next_val;         iRd_Data2 = next_val + 16'd1;
                        iRd_Data3 = next_val + 16'd2; iRd_Data4 = next_val + 16'd3;
                        next_val  = next_val + 16'd4;
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_req_level(input bit level, input int limit, input string name);
        int k;
        k = 0;
        while (oRd_Req !== level && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (oRd_Req !== level) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: oRd_Req never reached %0d within %0d cycles", name, level, limit);
        end
    endtask

    initial begin
        int          nbefore, k;
        logic [15:0] d0;

        // Reset state
        cycles(3);
        check("reset_rd_req", oRd_Req, 1'b0);
        check("reset_rd_addr", oRd_Addr, 24'h0);
        check("reset_pix_valid", oPix_Valid, 1'b0);
        check("reset_pix_data", oPix_Data, 16'h0);
        check("reset_wrap", oFrame_Wrap, 1'b0);
        check("reset_ucnt", oUnderrun_Cnt, 16'h0);

        // Basic fetch and full frame with no pops
        nreq = 0; nwrap = 0; req_log.delete();
        rst = 1'b0; en = 1'b1;
        wait_req_level(1'b1, 20, "first_req");
        check("first_req_addr", oRd_Addr, 24'h0);
        cycles(100);
        check("frame_req_count", nreq, 4);
        for (int i = 0; i < 4; i++)
            check("frame_req_addr", (i < req_log.size()) ? req_log[i] : 24'hFFFFFF, 24'(4 * i));
        check("frame_wrap_count", nwrap, 1);
        check("head_after_fill", oPix_Data, 16'd1);
        check("valid_after_fill", oPix_Valid, 1'b1);

        // Continuous pop while bursts keep arriving
        pop_log.delete();
        iPix_Pop = 1'b1;
        cycles(60);
        iPix_Pop = 1'b0;
        check("pop_stream_len_ok", pop_log.size() >= 20, 1'b1);
        for (int i = 0; i < pop_log.size(); i++)
            check("pop_order", pop_log[i], 16'(i + 1));

        // Restart during the request at address 8
        iFrame_Start = 1'b1; cycles(1); iFrame_Start = 1'b0;
        k = 0;
        while (!(oRd_Req && oRd_Addr == 24'd8) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("req_at_8_seen", oRd_Req && oRd_Addr == 24'd8, 1'b1);
        iFrame_Start = 1'b1; cycles(1); iFrame_Start = 1'b0;
        wait_req_level(1'b0, 20, "restart_req_drop");
        wait_req_level(1'b1, 20, "restart_next_req");
        check("restart_next_addr", oRd_Addr, 24'h0);
        check("restart_fifo_empty", oPix_Valid, 1'b0);

        // Underruns and a stray done while idle
        en = 1'b0;
        cycles(30);
        iFrame_Start = 1'b1; cycles(1); iFrame_Start = 1'b0;
        cycles(3);
        arb_on = 1'b0;
        iRd_Done = 1'b1; iRd_Data1 = 16'hDEAD; cycles(1); iRd_Done = 1'b0;
        cycles(3);
        arb_on = 1'b1;
        check("stray_done_no_req", oRd_Req, 1'b0);
        check("stray_done_empty", oPix_Valid, 1'b0);
        d0 = oPix_Data;
        iPix_Pop = 1'b1; cycles(3); iPix_Pop = 1'b0;
        cycles(2);
`ifdef FETCH_UNDERRUN_CNT_EN
        check("underrun_cnt_3", oUnderrun_Cnt, 16'd3);
`else
        check("underrun_cnt_off", oUnderrun_Cnt, 16'd0);
`endif
        check("underrun_data_hold", oPix_Data, d0);

        // en dropped during a request
        en = 1'b1;
        wait_req_level(1'b1, 20, "en_req");
        en = 1'b0;
        nbefore = nreq;
        cycles(30);
        check("en_low_no_new_req", nreq, nbefore);
        check("en_low_burst_pushed", oPix_Valid, 1'b1);
        en = 1'b1;
        wait_req_level(1'b1, 20, "en_resume_req");
        check("en_resume_count", nreq, nbefore + 1);

        // Randomized traffic against the model
        arb_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en           = ($urandom_range(0, 7) != 0);
            iPix_Pop     = ($urandom_range(0, 1) == 1);
            iFrame_Start = ($urandom_range(0, 199) == 0);
            rst          = ($urandom_range(0, 699) == 0);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; iPix_Pop = 1'b0; iFrame_Start = 1'b0;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
